// File: rtl/regwb_queue_pkg.sv
// Constants shared by the write-back queue, the register file and the hazard unit.
package regwb_queue_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int REG_ZERO   = 0;
  localparam int WBQ_DEPTH  = 4;

endpackage

// File: rtl/regwb_queue_match.sv
// Combinational youngest-match search over the valid entries of the write-back queue.
module regwb_match
  import regwb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] lk_reg,
  input  logic [ADDR_W-1:0] ent_reg [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [CNT_W-1:0]  count,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the one nearest the tail.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_reg[idx] == lk_reg) &&
          (lk_reg != ADDR_W'(REG_ZERO))) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/regwb_queue.sv
// In-order write-back queue feeding the register-file write port in cycles the
// main pipeline leaves free, with a two-port bypass lookup for decode.
module regwb_queue
  import regwb_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] lk_reg1,
  input  logic [ADDR_W-1:0] lk_reg2,
  output logic              lk_hit1,
  output logic [DATA_W-1:0] lk_data1,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data2,
  output logic [ADDR_W-1:0] count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push_fire;
  logic store;
  logic pop;

  // Handshake: a request transfers at a rising edge where in_valid && in_ready.
  // in_ready depends only on registered occupancy, never on this cycle's pop.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign push_fire = in_valid && in_ready;
  assign store     = push_fire && (in_reg != ADDR_W'(REG_ZERO));
  assign pop       = !empty && !wb_stall;
  assign count     = ADDR_W'(count_q);

  assign RegWrite       = pop;
  assign Write_register = pop ? ent_reg_q[head_q]  : '0;
  assign Write_data     = pop ? ent_data_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (store) begin
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(store) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; head/tail/count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (store && !reset) begin
      ent_reg_q[tail_q]  <= in_reg;
      ent_data_q[tail_q] <= in_data;
    end
  end

  regwb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match1 (
    .lk_reg  (lk_reg1),
    .ent_reg (ent_reg_q),
    .ent_data(ent_data_q),
    .head    (head_q),
    .count   (count_q),
    .hit     (lk_hit1),
    .data    (lk_data1)
  );

  regwb_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match2 (
    .lk_reg  (lk_reg2),
    .ent_reg (ent_reg_q),
    .ent_data(ent_data_q),
    .head    (head_q),
    .count   (count_q),
    .hit     (lk_hit2),
    .data    (lk_data2)
  );

endmodule

// File: tb/tb_regwb_queue.sv
// Directed-vector bench for regwb_queue: each scenario task drives and checks inline.
module tb_regwb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  lk_reg1;
  logic [4:0]  lk_reg2;
  logic        lk_hit1;
  logic [31:0] lk_data1;
  logic        lk_hit2;
  logic [31:0] lk_data2;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_vec;
  int n_err;

  regwb_queue dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .wb_stall      (wb_stall),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_data    (Write_data),
    .lk_reg1       (lk_reg1),
    .lk_reg2       (lk_reg2),
    .lk_hit1       (lk_hit1),
    .lk_data1      (lk_data1),
    .lk_hit2       (lk_hit2),
    .lk_data2      (lk_data2),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_reg = 5'd3; in_data = 32'hAAAA_0003;
    wb_stall = 1'b0; lk_reg1 = 5'd3; lk_reg2 = 5'd0;
    tick();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (lk_hit1 !== 1'b0) begin n_err++; $display("FAIL reset_lk_hit1 got %b want 0", lk_hit1); end
    n_vec++; if (Write_data !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", Write_data); end
  endtask

  task automatic test_basic_drain();
    wb_stall = 1'b0;
    push(5'd5, 32'hDEAD_BEEF);
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL drain_regwrite got %b want 1", RegWrite); end
    n_vec++; if (Write_register !== 5'd5) begin n_err++; $display("FAIL drain_wreg got %0d want 5", Write_register); end
    n_vec++; if (Write_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL drain_wdata got %h want deadbeef", Write_data); end
    n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL drain_count got %0d want 1", count); end
    tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL drain_idle got %b want 0", RegWrite); end
  endtask

  task automatic test_full();
    wb_stall = 1'b1;
    for (int r = 1; r <= 4; r++) push(5'(r), 32'h100 + 32'(r));
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", full); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", in_ready); end
    n_vec++; if (count !== 5'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL full_stall_rw got %b want 0", RegWrite); end
    // Fifth request is held off while full, including the first draining cycle.
    in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h999;
    tick();
    n_vec++; if (count !== 5'd4) begin n_err++; $display("FAIL full_held_count got %0d want 4", count); end
    wb_stall = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready got %b want 0", in_ready); end
    for (int r = 1; r <= 4; r++) begin
      n_vec++; if (RegWrite !== 1'b1 || Write_register !== 5'(r) || Write_data !== 32'h100 + 32'(r)) begin
        n_err++; $display("FAIL full_order_%0d got rw=%b reg=%0d data=%h want rw=1 reg=%0d data=%h",
                          r, RegWrite, Write_register, Write_data, r, 32'h100 + 32'(r));
      end
      tick();
      in_valid = 1'b0;
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_drained got count=%0d want 0", count); end
  endtask

  task automatic test_bypass();
    wb_stall = 1'b1;
    lk_reg1 = 5'd7; lk_reg2 = 5'd0;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    n_vec++; if (lk_hit1 !== 1'b1) begin n_err++; $display("FAIL byp_hit1 got %b want 1", lk_hit1); end
    n_vec++; if (lk_data1 !== 32'h22) begin n_err++; $display("FAIL byp_young got %h want 22", lk_data1); end
    n_vec++; if (lk_hit2 !== 1'b0 || lk_data2 !== 32'h0) begin n_err++; $display("FAIL byp_zero got hit=%b data=%h want 0/0", lk_hit2, lk_data2); end
    // In-flight request is not visible until it is stored.
    lk_reg2 = 5'd3; in_valid = 1'b1; in_reg = 5'd3; in_data = 32'h33;
    #1;
    n_vec++; if (lk_hit2 !== 1'b0) begin n_err++; $display("FAIL byp_inflight got %b want 0", lk_hit2); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (lk_hit2 !== 1'b1 || lk_data2 !== 32'h33) begin n_err++; $display("FAIL byp_stored got hit=%b data=%h want 1/33", lk_hit2, lk_data2); end
    wb_stall = 1'b0;
    #1;
    n_vec++; if (Write_register !== 5'd7 || Write_data !== 32'h11) begin n_err++; $display("FAIL byp_pop0 got %0d/%h want 7/11", Write_register, Write_data); end
    tick();
    n_vec++; if (Write_data !== 32'h22 || lk_hit1 !== 1'b1 || lk_data1 !== 32'h22) begin
      n_err++; $display("FAIL byp_popping got wd=%h hit=%b data=%h want 22/1/22", Write_data, lk_hit1, lk_data1);
    end
    tick();
    n_vec++; if (Write_register !== 5'd3 || Write_data !== 32'h33 || lk_hit1 !== 1'b0) begin
      n_err++; $display("FAIL byp_last got %0d/%h hit=%b want 3/33/0", Write_register, Write_data, lk_hit1);
    end
    tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL byp_empty got %b want 1", empty); end
  endtask

  task automatic test_reg_zero();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h55;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (count !== 5'd0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_stored got count=%0d rw=%b want 0/0", count, RegWrite); end
    tick();
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL r0_write got %b want 0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    wb_stall = 1'b1;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    wb_stall = 1'b0;
    #1;
    n_vec++; if (Write_register !== 5'd10) begin n_err++; $display("FAIL rmid_first got %0d want 10", Write_register); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if (count !== 5'd0 || RegWrite !== 1'b0 || empty !== 1'b1 || Write_data !== 32'h0) begin
      n_err++; $display("FAIL rmid_flush got count=%0d rw=%b empty=%b wd=%h want 0/0/1/0", count, RegWrite, empty, Write_data);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (RegWrite) seen = 1'b1;
      tick();
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_leak got write=%b want 0", seen); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0;
    wb_stall = 1'b0; lk_reg1 = '0; lk_reg2 = '0;
    test_reset();
    test_basic_drain();
    test_full();
    test_bypass();
    test_reg_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
